// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM core generator.
package pwm_pkg;

    localparam int PWM_R    = 8;
    localparam int PWM_DT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DEAD = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time FSM: maps the raw compare result onto a complementary high/low pair
// with a guaranteed both-low gap of dead_s clocks on every side change.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = PWM_DT_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_s,
    output logic            o_pwm_h,
    output logic            o_pwm_l
);

    localparam logic [DT_W-1:0] DT_ZERO = {DT_W{1'b0}};
    localparam logic [DT_W-1:0] DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

    pwm_state_t      state_r;
    pwm_state_t      state_next_s;
    logic [DT_W-1:0] dt_cnt_r;
    logic [DT_W-1:0] dt_cnt_next_s;

    // State and dead-time counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= S_IDLE;
            dt_cnt_r <= DT_ZERO;
        end else begin
            state_r  <= state_next_s;
            dt_cnt_r <= dt_cnt_next_s;
        end
    end

    // Next-state logic; the dead-time exit side is chosen by raw at the end of the gap
    always_comb begin
        state_next_s  = state_r;
        dt_cnt_next_s = dt_cnt_r;
        if (!i_en) begin
            state_next_s  = S_IDLE;
            dt_cnt_next_s = DT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_next_s = raw ? S_HIGH : S_LOW;
                end
                S_HIGH: begin
                    if (!raw) begin
                        if (dead_s == DT_ZERO) begin
                            state_next_s = S_LOW;
                        end else begin
                            state_next_s  = S_DEAD;
                            dt_cnt_next_s = dead_s;
                        end
                    end else begin
                        state_next_s = S_HIGH;
                    end
                end
                S_LOW: begin
                    if (raw) begin
                        if (dead_s == DT_ZERO) begin
                            state_next_s = S_HIGH;
                        end else begin
                            state_next_s  = S_DEAD;
                            dt_cnt_next_s = dead_s;
                        end
                    end else begin
                        state_next_s = S_LOW;
                    end
                end
                S_DEAD: begin
                    if (dt_cnt_r <= DT_ONE) begin
                        state_next_s  = raw ? S_HIGH : S_LOW;
                        dt_cnt_next_s = DT_ZERO;
                    end else begin
                        dt_cnt_next_s = dt_cnt_r - DT_ONE;
                    end
                end
                default: begin
                    state_next_s  = S_IDLE;
                    dt_cnt_next_s = DT_ZERO;
                end
            endcase
        end
    end

    // Output decode straight from the state register, so the drives never glitch
    always_comb begin
        o_pwm_h = (state_r == S_HIGH);
        o_pwm_l = (state_r == S_LOW);
    end

endmodule

// File: rtl/pwm_core_gen.sv
// PWM core: free-running period counter, boundary-shadowed duty/period/dead-time
// words and the duty comparator feeding the dead-time FSM.
module pwm_core_gen
    import pwm_pkg::*;
#(
    parameter int R    = PWM_R,
    parameter int DT_W = PWM_DT_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [R-1:0]    i_duty_cycle,
    input  logic [R-1:0]    i_switch_freq,
    input  logic [DT_W-1:0] i_dead_time,
    output logic            o_pwm_h,
    output logic            o_pwm_l,
    output logic            o_period_start,
    output logic [R-1:0]    o_cnt
);

    localparam logic [R-1:0] CNT_ZERO = {R{1'b0}};
    localparam logic [R-1:0] CNT_ONE  = {{(R-1){1'b0}}, 1'b1};

    logic [R-1:0]    cnt_r;
    logic [R-1:0]    duty_shadow_r;
    logic [R-1:0]    top_shadow_r;
    logic [DT_W-1:0] dead_shadow_r;
    logic            raw_s;

    // Period counter and shadow registers; shadows only move at a period boundary or while idle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r         <= CNT_ZERO;
            duty_shadow_r <= CNT_ZERO;
            top_shadow_r  <= CNT_ZERO;
            dead_shadow_r <= {DT_W{1'b0}};
        end else if (!i_en || (cnt_r == top_shadow_r)) begin
            cnt_r         <= CNT_ZERO;
            duty_shadow_r <= i_duty_cycle;
            top_shadow_r  <= i_switch_freq;
            dead_shadow_r <= i_dead_time;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Compare and status decode; period_start is masked during reset so it drops asynchronously
    always_comb begin
        raw_s          = (cnt_r < duty_shadow_r);
        o_cnt          = cnt_r;
        o_period_start = i_en & ~i_rst & (cnt_r == CNT_ZERO);
    end

    pwm_deadtime #(
        .DT_W (DT_W)
    ) u_deadtime (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .raw     (raw_s),
        .dead_s  (dead_shadow_r),
        .o_pwm_h (o_pwm_h),
        .o_pwm_l (o_pwm_l)
    );

endmodule
